// File: rtl/xadc_drp_sequencer.sv
`timescale 1ns/1ps
// XADC DRP poller: each EOS starts a sweep of seven reads (TEMP..AUX15) and publishes the results.
// The first den follows EOS by 1 cycle, with one read in flight at a time; a missing drdy times out per channel, and an EOS while busy is queued one deep.
module xadc_drp_sequencer #(
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [6:0] ADDR_TEMP      = 7'h00,
  parameter logic [6:0] ADDR_VCCINT    = 7'h01,
  parameter logic [6:0] ADDR_VCCBRAM   = 7'h06,
  parameter logic [6:0] ADDR_AUX6      = 7'h16,
  parameter logic [6:0] ADDR_AUX7      = 7'h17,
  parameter logic [6:0] ADDR_AUX14     = 7'h1E,
  parameter logic [6:0] ADDR_AUX15     = 7'h1F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eos_in,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic        den_out,
  output logic        dwe_out,
  output logic [6:0]  daddr_out,
  output logic [15:0] di_out,
  output logic [15:0] MEASURED_TEMP,
  output logic [15:0] MEASURED_VCCINT,
  output logic [15:0] MEASURED_VCCBRAM,
  output logic [15:0] MEASURED_AUX6,
  output logic [15:0] MEASURED_AUX7,
  output logic [15:0] MEASURED_AUX14,
  output logic [15:0] MEASURED_AUX15,
  output logic        sweep_done,
  output logic        timeout_err,
  output logic        overrun
);
  localparam int            CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_IDX = 3'd6;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ADV} state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q;
  logic          pending_q;
  logic          timed_out;
  logic [15:0]   meas_q [7];

  function automatic logic [6:0] addr_of(input logic [2:0] i);
    case (i)
      3'd0:    addr_of = ADDR_TEMP;
      3'd1:    addr_of = ADDR_VCCINT;
      3'd2:    addr_of = ADDR_VCCBRAM;
      3'd3:    addr_of = ADDR_AUX6;
      3'd4:    addr_of = ADDR_AUX7;
      3'd5:    addr_of = ADDR_AUX14;
      default: addr_of = ADDR_AUX15;
    endcase
  endfunction

  // Last WAIT cycle of the budget with no drdy: abandon this channel.
  assign timed_out = (state_q == WAIT) && !drdy_in && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (pending_q || eos_in) begin
          state_d = ISSUE;
          idx_d   = 3'd0;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (drdy_in || timed_out) state_d = ADV;
      end
      ADV: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          state_d = ISSUE;
          idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= 3'd0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      daddr_out   <= 7'd0;
      sweep_done  <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < 7; i++) meas_q[i] <= 16'd0;
    end else begin
      idx_q      <= idx_d;
      sweep_done <= (state_q == ADV) && (idx_q == LAST_IDX);
      if (state_d == ISSUE) daddr_out <= addr_of(idx_d);
      if (state_q == ISSUE) cnt_q <= '0;
      else if ((state_q == WAIT) && !drdy_in && !timed_out) cnt_q <= cnt_q + 1'b1;
      if (timed_out) timeout_err <= 1'b1;
      if ((state_q == WAIT) && drdy_in) begin
        for (int i = 0; i < 7; i++) begin
          if (idx_q == 3'(i)) meas_q[i] <= do_in;
        end
      end
      // One-deep EOS queue; IDLE always consumes it.
      if (state_q == IDLE) begin
        pending_q <= 1'b0;
      end else if (eos_in) begin
        if (pending_q) overrun <= 1'b1;
        pending_q <= 1'b1;
      end
    end
  end

  assign den_out          = (state_q == ISSUE);
  assign dwe_out          = 1'b0;
  assign di_out           = 16'd0;
  assign MEASURED_TEMP    = meas_q[0];
  assign MEASURED_VCCINT  = meas_q[1];
  assign MEASURED_VCCBRAM = meas_q[2];
  assign MEASURED_AUX6    = meas_q[3];
  assign MEASURED_AUX7    = meas_q[4];
  assign MEASURED_AUX14   = meas_q[5];
  assign MEASURED_AUX15   = meas_q[6];

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
`timescale 1ns/1ps
// Bench for xadc_drp_sequencer: directed scenarios with a DRP responder, a timeline model
// checked every cycle, and literal expectations for the key scenarios.
module tb_xadc_drp_sequencer;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        eos_in = 1'b0;
  logic        drdy_in = 1'b0;
  logic [15:0] do_in = 16'd0;
  logic        den_out, dwe_out, sweep_done, timeout_err, overrun;
  logic [6:0]  daddr_out;
  logic [15:0] di_out;
  logic [15:0] m_temp, m_vccint, m_vccbram, m_aux6, m_aux7, m_aux14, m_aux15;
  logic [111:0] dut_meas;

  xadc_drp_sequencer dut (
    .clk(clk), .rst(rst), .eos_in(eos_in), .drdy_in(drdy_in), .do_in(do_in),
    .den_out(den_out), .dwe_out(dwe_out), .daddr_out(daddr_out), .di_out(di_out),
    .MEASURED_TEMP(m_temp), .MEASURED_VCCINT(m_vccint), .MEASURED_VCCBRAM(m_vccbram),
    .MEASURED_AUX6(m_aux6), .MEASURED_AUX7(m_aux7), .MEASURED_AUX14(m_aux14),
    .MEASURED_AUX15(m_aux15), .sweep_done(sweep_done), .timeout_err(timeout_err),
    .overrun(overrun)
  );

  assign dut_meas = {m_temp, m_vccint, m_vccbram, m_aux6, m_aux7, m_aux14, m_aux15};

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [6:0] tab [7] = '{7'h00, 7'h01, 7'h06, 7'h16, 7'h17, 7'h1E, 7'h1F};

  // DRP responder controls and event logs
  bit          rnd_delay = 0, rnd_val = 0, withhold = 0, abcd = 0;
  int          fix_delay = 1;
  logic [15:0] val_base = 16'h1000;
  int          resp_cnt = 0;
  logic [15:0] resp_val = 16'd0;
  int          den_cyc_q[$];
  logic [6:0]  den_addr_q[$];
  int          done_log[$];
  int          terr_cyc = -1;

  task automatic clear_logs();
    den_cyc_q.delete();
    den_addr_q.delete();
    done_log.delete();
  endtask

  task automatic tick(input logic eos, input logic late);
    @(posedge clk);
    #1;
    eos_in  = eos;
    drdy_in = 1'b0;
    do_in   = 16'd0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        drdy_in = 1'b1;
        do_in   = resp_val;
      end
    end
    if (late) begin
      drdy_in = 1'b1;
      do_in   = 16'hDEAD;
    end
    if (den_out) begin
      den_cyc_q.push_back(cyc);
      den_addr_q.push_back(daddr_out);
      if (!(withhold && daddr_out == 7'h17)) begin
        resp_cnt = rnd_delay ? int'($urandom_range(10, 1)) : fix_delay;
        if (rnd_val) resp_val = 16'($urandom());
        else if (abcd && daddr_out == 7'h17) resp_val = 16'hABCD;
        else resp_val = val_base + {9'd0, daddr_out};
      end
    end
    if (sweep_done) done_log.push_back(cyc);
    if (timeout_err && terr_cyc < 0) terr_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n0;
    int k;
    n0 = done_log.size();
    k = 0;
    while (done_log.size() == n0 && k < budget) begin
      tick(1'b0, 1'b0);
      k++;
    end
    chk(name, done_log.size() != n0, 1);
  endtask

  // Timeline model: predicts when each read is issued, when it completes and what it leaves behind.
  bit          busy = 0, in_wait = 0, m_pend = 0, m_ovr = 0, m_terr = 0, prev_den = 0;
  int          ch = 0, issue_cyc = -1, done_cyc = -1, idle_from = 0;
  logic [15:0] m_meas [7];

  initial begin : compare
    bit exp_den, idle_now, resp;
    for (int i = 0; i < 7; i++) m_meas[i] = 16'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy = 0; in_wait = 0; m_pend = 0; m_ovr = 0; m_terr = 0;
        ch = 0; issue_cyc = -1; done_cyc = -1; idle_from = 0;
        for (int i = 0; i < 7; i++) m_meas[i] = 16'd0;
        chk("reset_outputs", {den_out, daddr_out, sweep_done, timeout_err, overrun, dut_meas}, '0);
      end else begin
        exp_den = busy && (cyc == issue_cyc);
        chk("den", den_out, exp_den);
        if (exp_den) chk("daddr", daddr_out, tab[ch]);
        chk("den_back_to_back", prev_den && den_out, 0);
        chk("sweep_done", sweep_done, cyc == done_cyc);
        chk("timeout_err", timeout_err, m_terr);
        chk("overrun", overrun, m_ovr);
        chk("measured", dut_meas,
            {m_meas[0], m_meas[1], m_meas[2], m_meas[3], m_meas[4], m_meas[5], m_meas[6]});
        chk("write_tieoff", {dwe_out, di_out}, 0);

        idle_now = !busy && (cyc >= idle_from);
        resp = 0;
        if (busy && in_wait) begin
          if (drdy_in) begin
            m_meas[ch] = do_in;
            resp = 1;
          end else if (cyc - issue_cyc == TIMEOUT) begin
            m_terr = 1;
            resp = 1;
          end
          if (resp) begin
            in_wait = 0;
            if (ch < 6) begin
              ch++;
              issue_cyc = cyc + 2;
            end else begin
              busy = 0;
              done_cyc = cyc + 2;
              idle_from = cyc + 2;
            end
          end
        end else if (busy && cyc == issue_cyc) begin
          in_wait = 1;
        end
        if (idle_now) begin
          if (m_pend || eos_in) begin
            m_pend = 0;
            busy = 1;
            ch = 0;
            issue_cyc = cyc + 1;
          end
        end else if (eos_in) begin
          if (m_pend) m_ovr = 1;
          else m_pend = 1;
        end
      end
      prev_den = rst && den_out;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  t;
    int  te;
    int  n0;
    int  aux7_cyc;
    bit  found;

    // Reset and a single clean sweep
    repeat (3) tick(1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b0, 1'b0);
    clear_logs();
    tick(1'b1, 1'b0);
    t = cyc;
    wait_done(40, "t1_done");
    chk("t1_nden", den_addr_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < den_addr_q.size()) chk($sformatf("t1_addr%0d", i), den_addr_q[i], tab[i]);
    end
    if (den_cyc_q.size() > 0 && done_log.size() > 0) begin
      chk("t1_first_den", den_cyc_q[0] - t, 1);
      chk("t1_sweep_latency", done_log[0] - den_cyc_q[0], 21);
    end
    chk("t1_temp", m_temp, 16'h1000);
    chk("t1_aux15", m_aux15, 16'h101F);
    chk("t1_terr", timeout_err, 0);

    // AUX7 loads ABCD, then a sweep where AUX7 never answers
    abcd = 1;
    tick(1'b1, 1'b0);
    wait_done(40, "t2a_done");
    chk("t2_aux7_prior", m_aux7, 16'hABCD);
    abcd = 0;
    withhold = 1;
    val_base = 16'h2000;
    terr_cyc = -1;
    clear_logs();
    tick(1'b1, 1'b0);
    wait_done(150, "t2b_done");
    aux7_cyc = -1;
    foreach (den_addr_q[k]) if (den_addr_q[k] == 7'h17) aux7_cyc = den_cyc_q[k];
    chk("t2_timeout_at", terr_cyc - aux7_cyc, 65);
    chk("t2_terr", timeout_err, 1);
    chk("t2_aux7_kept", m_aux7, 16'hABCD);
    chk("t2_aux14", m_aux14, 16'h201E);
    chk("t2_aux15", m_aux15, 16'h201F);
    chk("t2_ndone", done_log.size(), 1);
    withhold = 0;

    // Two EOS during one sweep: one queued, one overrun
    val_base = 16'h3000;
    clear_logs();
    tick(1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (70) tick(1'b0, 1'b0);
    chk("t3_ndone", done_log.size(), 2);
    chk("t3_overrun", overrun, 1);

    rst = 1'b0;
    resp_cnt = 0;
    repeat (2) tick(1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b0, 1'b0);
    chk("t3_sticky_cleared", {timeout_err, overrun}, 0);

    // EOS on the final ADV cycle
    val_base = 16'h4000;
    clear_logs();
    tick(1'b1, 1'b0);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick(1'b0, 1'b0);
      found = den_out && (daddr_out == 7'h1F);
    end
    chk("t4_find_aux15", found, 1);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    te = cyc;
    n0 = den_cyc_q.size();
    for (int k = 0; k < 10 && den_cyc_q.size() == n0; k++) tick(1'b0, 1'b0);
    if (den_cyc_q.size() > n0) chk("t4_restart_gap", den_cyc_q[n0] - te, 2);
    else chk("t4_restart_gap", 0, 2);
    wait_done(40, "t4_done");
    chk("t4_overrun", overrun, 0);

    // Reset while waiting on VCCBRAM, then a stray drdy
    val_base = 16'h5000;
    fix_delay = 5;
    tick(1'b1, 1'b0);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick(1'b0, 1'b0);
      found = den_out && (daddr_out == 7'h06);
    end
    chk("t5_find_vccbram", found, 1);
    tick(1'b0, 1'b0);
    chk("t5_temp_before", m_temp, 16'h5000);
    rst = 1'b0;
    resp_cnt = 0;
    #1;
    chk("t5_den_reset", den_out, 0);
    chk("t5_meas_reset", dut_meas, 0);
    repeat (2) tick(1'b0, 1'b0);
    rst = 1'b1;
    clear_logs();
    tick(1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
    chk("t5_late_ignored", dut_meas, 0);
    chk("t5_idle", den_cyc_q.size(), 0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("t5_restart", {den_out, daddr_out}, 8'h80);
    wait_done(100, "t5_done");
    fix_delay = 1;

    // Random drdy delays and data
    rnd_delay = 1;
    rnd_val = 1;
    for (int s = 0; s < 100; s++) begin
      tick(1'b1, 1'b0);
      wait_done(150, "t6_done");
    end
    chk("t6_flags", {timeout_err, overrun}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
